fp_norm_pack: RTL
=================

Name: fp_norm_pack

Overview:
- Back end of the FPU add/sub datapath. Accepts the unpacked result triple from the adder/subtractor (sign, signed unbiased exponent, 27-bit mantissa with guard/round/sticky).
- Normalizes the mantissa with a multi-cycle left-shift loop, then rounds to nearest-even.
- Packs an IEEE-754 single-precision word and raises exception flags.
- Uses a valid/ready handshake on both sides so the producer and register writeback can stall independently.

Parameters:
- ROUND_EN, 1, 1 = round-to-nearest-even; 0 = truncate (G/R/S still drive inexact).
- QNAN, 32'h7FC00000, canonical quiet NaN emitted for any NaN input.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  producer has a triple
- in_ready  out  1  block can accept; high only in IDLE
- z_s  in  1  sign
- z_e  in  8  signed unbiased exponent; 8'h80 = inf/NaN class
- z_m  in  27  [26] integer bit, [25:3] fraction, [2] guard, [1] round, [0] sticky
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts
- result  out  32  packed single
- flags  out  3  {overflow, underflow, inexact}

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low. Reset forces state IDLE and clears all output registers: in_ready=1, out_valid=0, result=0, flags=0. Reset mid-operation discards the in-flight op.
- States and transitions:
  - IDLE: accept when in_valid&&in_ready and register s/e/m.
    - z_e==8'h80: go to DONE next cycle. z_m==0 gives {z_s,8'hFF,23'h0}; otherwise QNAN. Flags 0.
    - z_m==0: go to DONE with {z_s,31'h0}. Flags 0.
    - Otherwise go to NORM.
  - NORM: one bit per cycle. If m[26]==0 and e>-126: m<<=1, e-=1, stay. Else go to ROUND. A normalized input spends exactly one cycle here; the maximum is 27 cycles.
  - ROUND: lsb=m[3], G=m[2], R=m[1], S=m[0].
    - Round up when ROUND_EN && G && (R|S|lsb); add 1 at bit 3 using a 25-bit sum.
    - Carry out: mantissa>>=1, e+=1.
    - Next state is DONE.
  - DONE: out_valid=1. result and flags are stable while out_valid&&!out_ready. On handshake go to IDLE, with out_valid low the next cycle.
- Latency, handshake to first out_valid cycle: specials and zero take 1 cycle. Normalized inputs take 3 cycles. Each extra shift adds 1 cycle.
- Throughput: one op in flight. in_ready is low in NORM, ROUND and DONE. There is no acceptance in the cycle out_valid drops.
- Pack rules:
  - e>127 after rounding: result {s,8'hFF,0}, overflow=1, inexact=1.
  - Else if m[26]==1: biased exponent = e+127 (8-bit) and fraction = m[25:3].
  - Else (subnormal): exponent field 0 and fraction = m[25:3].
  - A subnormal that rounds up into m[26] packs as exponent 1.
- Flags:
  - inexact = G|R|S at ROUND.
  - underflow = inexact && result is subnormal or zero after rounding.
  - overflow as above.
- Inputs z_* are sampled only on the accept edge and may change freely otherwise.

Decomposition:
- Shared package fp_pkg:
  - state encoding (IDLE, NORM, ROUND, DONE);
  - EXP_BIAS=127, EXP_MIN=-126, EXP_SPECIAL=8'h80;
  - mantissa bit-field indices (INT_BIT=26, GRS_LSB=0);
  - flag bit positions.
- One sub-module is natural: fp_round_rne. It is combinational: {m, e, ROUND_EN} in; {m', e', inexact} out. It can later be reused by the multiplier path.

Test Plan:
- 1.0: z_s=0, z_e=0, z_m=27'h4000000 → result 32'h3F800000, flags 0, out_valid 3 cycles after accept.
- Two-shift normalize: z_e=1, z_m=27'h1000000 → 32'h3F000000 at 5 cycles.
- RNE: z_e=0, z_m=27'h4000004 → 32'h3F800000, flags 3'b001. z_m=27'h400000C → 32'h3F800002, flags 3'b001. With ROUND_EN=0, z_m=27'h400000C → 32'h3F800001, flags 3'b001.
- Overflow by rounding: z_e=127, z_m=27'h7FFFFFC → 32'h7F800000, flags 3'b101.
- Specials and subnormal:
  - z_e=8'h80, z_m=0, z_s=1 → 32'hFF800000 one cycle after accept.
  - z_e=8'h80, z_m=1 → 32'h7FC00000.
  - z_e=8'h82 (-126), z_m=27'h2000000 → 32'h00400000, flags 0.
- Backpressure/reset:
  - Hold out_ready=0 for 10 cycles → result stable, in_ready=0.
  - Assert reset during NORM of the two-shift case → out_valid=0, in_ready=1 immediately. The next op completes correctly.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the FPU add/sub back end: FSM encoding, exponent
// constants, mantissa bit-field positions and flag bit positions.
package fp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } fp_state_e;

  // Working mantissa: [26] integer bit, [25:3] fraction, [2:0] guard/round/sticky
  localparam int MAN_W   = 27;
  localparam int SIG_W   = 24;
  localparam int INT_BIT = 26;
  localparam int LSB_BIT = 3;
  localparam int GRS_LSB = 0;

  // Internal exponent is wider than the 8-bit input so +1 from rounding cannot wrap
  localparam int EXP_W = 10;
  localparam logic signed [EXP_W-1:0] EXP_BIAS = 10'sd127;
  localparam logic signed [EXP_W-1:0] EXP_MIN  = -10'sd126;
  localparam logic signed [EXP_W-1:0] EXP_MAX  = 10'sd127;
  localparam logic [7:0]              EXP_SPECIAL = 8'h80;

  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even on a 27-bit mantissa with G/R/S.
// Returns the 24-bit significand, the adjusted exponent and the inexact bit.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic                    round_en,
  input  logic [MAN_W-1:0]        m_in,
  input  logic signed [EXP_W-1:0] e_in,
  output logic [SIG_W-1:0]        m_out,
  output logic signed [EXP_W-1:0] e_out,
  output logic                    inexact
);

  // Increment at the LSB when above half, or exactly half with an odd LSB
  function automatic logic [SIG_W:0] rne_sum(input logic [MAN_W-1:0] m, input logic en);
    logic up;
    up = en & m[GRS_LSB+2] & (m[GRS_LSB+1] | m[GRS_LSB] | m[LSB_BIT]);
    return {1'b0, m[INT_BIT:LSB_BIT]} + {{SIG_W{1'b0}}, up};
  endfunction

  logic [SIG_W:0] sum;

  assign sum = rne_sum(m_in, round_en);

  always_comb begin
    inexact = |m_in[LSB_BIT-1:GRS_LSB];
    if (sum[SIG_W]) begin
      m_out = sum[SIG_W:1];
      e_out = e_in + 10'sd1;
    end else begin
      m_out = sum[SIG_W-1:0];
      e_out = e_in;
    end
  end

endmodule

// File: rtl/fp_norm_pack.sv
// Add/sub back end: iterative left-shift normalization, rounding, IEEE-754
// single packing and exception flags behind valid/ready handshakes.
module fp_norm_pack
  import fp_pkg::*;
#(
  parameter bit          ROUND_EN = 1'b1,
  parameter logic [31:0] QNAN     = 32'h7FC00000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             z_s,
  input  logic [7:0]       z_e,
  input  logic [MAN_W-1:0] z_m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic [2:0]       flags
);

  fp_state_e state, state_nxt;

  logic                    s_r;
  logic signed [EXP_W-1:0] e_r;
  logic [MAN_W-1:0]        m_r;

  logic                    accept;
  logic                    is_special;
  logic                    is_zero;
  logic                    do_shift;
  logic [31:0]             spec_res;

  logic [SIG_W-1:0]        m_rnd;
  logic signed [EXP_W-1:0] e_rnd;
  logic                    rnd_inexact;
  logic [31:0]             pack_res;
  logic [2:0]              pack_flg;

  assign in_ready   = (state == ST_IDLE);
  assign out_valid  = (state == ST_DONE);
  assign accept     = in_valid & in_ready;
  assign is_special = (z_e == EXP_SPECIAL);
  assign is_zero    = (z_m == '0);
  assign do_shift   = !m_r[INT_BIT] && (e_r > EXP_MIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (is_special || is_zero) ? ST_DONE : ST_NORM;
        end
      end
      ST_NORM: begin
        if (!do_shift) begin
          state_nxt = ST_ROUND;
        end
      end
      ST_ROUND: state_nxt = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---- accept / normalize: working operand registers ----
  always_ff @(posedge clk) begin
    if (accept) begin
      s_r <= z_s;
      e_r <= {{(EXP_W-8){z_e[7]}}, z_e};
      m_r <= z_m;
    end else if (state == ST_NORM && do_shift) begin
      m_r <= m_r << 1;
      e_r <= e_r - 10'sd1;
    end
  end

  always_comb begin
    spec_res = {z_s, 31'h0};
    if (is_special) begin
      spec_res = is_zero ? {z_s, 8'hFF, 23'h0} : QNAN;
    end
  end

  // ---- round / pack ----
  fp_round_rne u_round (
    .round_en (ROUND_EN),
    .m_in     (m_r),
    .e_in     (e_r),
    .m_out    (m_rnd),
    .e_out    (e_rnd),
    .inexact  (rnd_inexact)
  );

  always_comb begin
    pack_res = {s_r, 8'h00, m_rnd[SIG_W-2:0]};
    pack_flg = '0;
    if (e_rnd > EXP_MAX) begin
      pack_res           = {s_r, 8'hFF, 23'h0};
      pack_flg[FLAG_OVF] = 1'b1;
      pack_flg[FLAG_INX] = 1'b1;
    end else if (m_rnd[SIG_W-1]) begin
      pack_res           = {s_r, e_rnd[7:0] + EXP_BIAS[7:0], m_rnd[SIG_W-2:0]};
      pack_flg[FLAG_INX] = rnd_inexact;
    end else begin
      // Subnormal or zero after rounding; a subnormal carrying into the
      // integer bit took the branch above with exponent -126 -> field 1
      pack_flg[FLAG_UNF] = rnd_inexact;
      pack_flg[FLAG_INX] = rnd_inexact;
    end
  end

  // ---- output registers: held through DONE while the consumer stalls ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result <= '0;
      flags  <= '0;
    end else if (accept && (is_special || is_zero)) begin
      result <= spec_res;
      flags  <= '0;
    end else if (state == ST_ROUND) begin
      result <= pack_res;
      flags  <= pack_flg;
    end
  end

endmodule
